// File: rtl/sim_ctrl_pkg.sv
// Shared types and helpers for the simulation run controller.
// Holds the run-state encoding and the hold-counter sizing function.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

    // Wide enough to hold the value RESET_CYCLES itself, so terminal count never aliases.
    function automatic int unsigned hold_cnt_w(input int unsigned reset_cycles);
        return $clog2(reset_cycles + 1);
    endfunction

endpackage

// File: rtl/sim_hold_counter.sv
// Up-counter with synchronous clear, parallel load and a terminal-count flag.
// Used to time how long the DUT reset is held after the harness reset drops.
module sim_hold_counter #(
    parameter int unsigned W    = 2,
    parameter int unsigned TERM = 1
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    // NOTE: state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(TERM));

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for simulation harnesses: DUT reset sequencing, pausable cycle
// counter, bounded dump window, finish pulse and power-of-two enable strobes.
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned      CNT_W        = 32,
    parameter int unsigned      RESET_CYCLES = 2,
    parameter logic [CNT_W-1:0] MAX_CYCLES   = '0,
    parameter logic [CNT_W-1:0] DUMP_START   = '0,
    parameter logic [CNT_W-1:0] DUMP_STOP    = '1,
    parameter int unsigned      N_GATES      = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               pause,
    input  logic               trace_en,
    input  logic               dump_req,
    output logic               dut_rst_n,
    output logic [CNT_W-1:0]   cycle,
    output logic               cycle_tick,
    output logic               dump_on,
    output logic               finish,
    output logic               wrap,
    output logic [N_GATES-1:0] gate
);

    localparam int unsigned      HOLD_W    = hold_cnt_w(RESET_CYCLES);
    localparam logic             WIN_VALID = (DUMP_STOP > DUMP_START);
    localparam logic [CNT_W-1:0] WIN_LEN   = DUMP_STOP - DUMP_START;

    run_state_t       state;
    logic             hold_done;
    logic [CNT_W-1:0] cycle_nxt;

    sim_hold_counter #(
        .W    (HOLD_W),
        .TERM (RESET_CYCLES - 1)
    ) u_hold (
        .clk      (CLK),
        .clear    (RST),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == HOLD),
        .tc       (hold_done)
    );

    assign cycle_nxt = cycle + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= HOLD;
            dut_rst_n  <= 1'b0;
            cycle      <= '0;
            cycle_tick <= 1'b0;
            finish     <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            cycle_tick <= 1'b0;
            finish     <= 1'b0;
            wrap       <= 1'b0;
            case (state)
                HOLD: begin
                    if (hold_done) begin
                        state     <= RUN;
                        dut_rst_n <= 1'b1;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        cycle      <= cycle_nxt;
                        cycle_tick <= trace_en;
                        // Reaching the limit beats overflow, so an all-ones limit never wraps.
                        if ((MAX_CYCLES != '0) && (cycle_nxt == MAX_CYCLES)) begin
                            state  <= DONE;
                            finish <= 1'b1;
                        end else begin
                            wrap <= (cycle == '1);
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

    // Modular distance from the window start handles a window touching either end of the range.
    assign dump_on = WIN_VALID && (state != HOLD) && dump_req &&
                     ((cycle - DUMP_START) < WIN_LEN);

    for (genvar i = 0; i < N_GATES; i++) begin : g_gate
        if (i == 0) begin : g_first
            assign gate[i] = (state == RUN);
        end else begin : g_rest
            assign gate[i] = (state == RUN) && (cycle[i-1:0] == '0);
        end
    end

endmodule
